// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter with boot bubble, redirect, exception/eret
// vectoring and a one-entry buffer for a redirect that arrives while stalled.
//
// Parameters:
//   WIDTH       PC/address width in bits
//   RESET_ADDR  PC value loaded by reset
//   EXC_VECTOR  PC value loaded on exception
//   STEP        sequential increment in bytes
//
// Ports:
//   clk               sole clock, all state updates on its rising edge
//   reset             synchronous active-low reset
//   stall             freeze PC this cycle (ignored by exc_req/eret_req)
//   redirect_valid    branch/jump taken request
//   redirect_target   branch/jump target address
//   exc_req           exception request (highest priority)
//   eret_req          return-from-exception request
//   epc               return address for eret
//   pc                current fetch address (registered)
//   pc_plus           pc + STEP, wraps modulo 2^WIDTH
//   fetch_valid       pc holds a fetchable address (RUN or HOLD)
//   misaligned        pc is not a multiple of STEP
//   redirect_pending  a redirect is buffered awaiting stall release
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = 'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 'h0000_4180,
  parameter int               STEP       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             fetch_valid,
  output logic             misaligned,
  output logic             redirect_pending
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pc_n;
  logic [WIDTH-1:0] redirect_buf, redirect_buf_n;

  // Plain WIDTH-bit addition drops the carry, giving the silent wrap.
  assign pc_plus          = pc + WIDTH'(STEP);
  assign misaligned       = (pc % WIDTH'(STEP)) != '0;
  assign fetch_valid      = (state != BOOT);
  assign redirect_pending = (state == HOLD);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n        = state;
    pc_n           = pc;
    redirect_buf_n = redirect_buf;

    unique case (state)
      // One-cycle bubble: pc already holds RESET_ADDR, inputs are ignored.
      BOOT: state_n = RUN;

      RUN: begin
        if (exc_req) begin
          pc_n = EXC_VECTOR;
        end else if (eret_req) begin
          pc_n = epc;
        end else if (stall) begin
          // A redirect during a stall must not be lost: park it and wait.
          if (redirect_valid) begin
            redirect_buf_n = redirect_target;
            state_n        = HOLD;
          end
        end else if (redirect_valid) begin
          pc_n = redirect_target;
        end else begin
          pc_n = pc_plus;
        end
      end

      HOLD: begin
        if (exc_req || eret_req) begin
          // Exception/eret supersede the parked redirect.
          pc_n           = exc_req ? EXC_VECTOR : epc;
          redirect_buf_n = '0;
          state_n        = RUN;
        end else if (stall) begin
          if (redirect_valid) redirect_buf_n = redirect_target;  // latest wins
        end else begin
          pc_n           = redirect_valid ? redirect_target : redirect_buf;
          redirect_buf_n = '0;
          state_n        = RUN;
        end
      end

      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state        <= BOOT;
      pc           <= RESET_ADDR;
      redirect_buf <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      redirect_buf <= redirect_buf_n;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- directed self-checking bench for pc_unit (default params).
// Inputs change 1 ns after a rising edge and outputs are sampled there too,
// so every check sees the result of exactly one edge.
// ---------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        fetch_valid;
  logic        misaligned;
  logic        redirect_pending;

  int n_pass  = 0;
  int n_total = 0;

  pc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .exc_req          (exc_req),
    .eret_req         (eret_req),
    .epc              (epc),
    .pc               (pc),
    .pc_plus          (pc_plus),
    .fetch_valid      (fetch_valid),
    .misaligned       (misaligned),
    .redirect_pending (redirect_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_total++;
    assert (observed === expected) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // pc, fetch_valid, redirect_pending in one call.
  task automatic check_state(input string tag, input logic [31:0] exp_pc,
                             input logic exp_fv, input logic exp_pend);
    check({tag, ".pc"},      pc,                       exp_pc);
    check({tag, ".fv"},      {31'd0, fetch_valid},     {31'd0, exp_fv});
    check({tag, ".pending"}, {31'd0, redirect_pending}, {31'd0, exp_pend});
  endtask

  initial begin
    reset           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    exc_req         = 1'b0;
    eret_req        = 1'b0;
    epc             = '0;

    // Reset then free-run: boot bubble, then sequential fetch.
    step();
    check_state("reset", 32'h3000, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    check_state("boot_exit", 32'h3000, 1'b1, 1'b0);
    check("boot_exit.pc_plus", pc_plus, 32'h3004);
    check("boot_exit.misaligned", {31'd0, misaligned}, 32'd0);
    step();
    check("run1.pc", pc, 32'h3004);
    step();
    check("run2.pc", pc, 32'h3008);

    // Plain redirect.
    redirect_valid = 1'b1; redirect_target = 32'h3100;
    step();
    check("redir.pc", pc, 32'h3100);
    redirect_valid = 1'b0;
    step();
    check("redir_next.pc", pc, 32'h3104);

    // Stalled redirect: held three cycles, then released.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h3200;
    step();
    check_state("stall1", 32'h3104, 1'b1, 1'b1);
    redirect_valid = 1'b0;
    step();
    check_state("stall2", 32'h3104, 1'b1, 1'b1);
    step();
    check_state("stall3", 32'h3104, 1'b1, 1'b1);
    stall = 1'b0;
    step();
    check_state("release", 32'h3200, 1'b1, 1'b0);
    step();
    check("release_next.pc", pc, 32'h3204);

    // Latest buffered redirect wins.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h3300;
    step();
    redirect_target = 32'h3400;
    step();
    check_state("overwrite", 32'h3204, 1'b1, 1'b1);
    stall = 1'b0; redirect_valid = 1'b0;
    step();
    check_state("overwrite_release", 32'h3400, 1'b1, 1'b0);

    // Release with a fresh redirect in the same cycle takes the fresh one.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h3500;
    step();
    stall = 1'b0; redirect_target = 32'h3600;
    step();
    check_state("release_fresh", 32'h3600, 1'b1, 1'b0);

    // Everything at once while in HOLD: exception wins, buffer discarded.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h3700;
    step();
    check("pre_exc.pending", {31'd0, redirect_pending}, 32'd1);
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h5000;
    step();
    check_state("exc_all", 32'h4180, 1'b1, 1'b0);
    exc_req = 1'b0; eret_req = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    step();
    check("exc_next.pc", pc, 32'h4184);

    // eret overrides stall.
    eret_req = 1'b1; stall = 1'b1;
    step();
    check_state("eret", 32'h5000, 1'b1, 1'b0);
    eret_req = 1'b0; stall = 1'b0;
    step();
    check("eret_next.pc", pc, 32'h5004);

    // Wrap at the top of the address space, then a misaligned target.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    check("wrap_top.pc", pc, 32'hFFFF_FFFC);
    check("wrap_top.pc_plus", pc_plus, 32'h0000_0000);
    redirect_valid = 1'b0;
    step();
    check("wrap.pc", pc, 32'h0000_0000);
    redirect_valid = 1'b1; redirect_target = 32'h3102;
    step();
    check("misal.pc", pc, 32'h3102);
    check("misal.flag", {31'd0, misaligned}, 32'd1);
    redirect_valid = 1'b0;
    step();
    check("misal_next.pc", pc, 32'h3106);
    check("misal_next.flag", {31'd0, misaligned}, 32'd1);

    // Reset during HOLD drops the buffered redirect.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h3800;
    step();
    check_state("hold_pre_reset", 32'h3106, 1'b1, 1'b1);
    reset = 1'b0;
    step();
    check_state("reset_in_hold", 32'h3000, 1'b0, 1'b0);
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    step();
    check_state("post_reset_boot", 32'h3000, 1'b1, 1'b0);
    step();
    check("post_reset_run.pc", pc, 32'h3004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
